// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam logic TYPE_READ  = 1'b0;
    localparam logic TYPE_WRITE = 1'b1;

    // Access issued last cycle: which port owns the response and what kind it is.
    typedef struct packed {
        logic port;
        logic req_type;
    } pend_entry_t;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin grant: the pointer port wins when valid, otherwise the other.
module sram_arb_rr2 (
    input  logic [1:0] vals,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] grant,
    output logic       ptr_next
);

    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr;
        if (en) begin
            if (vals[ptr]) begin
                grant[ptr] = 1'b1;
                ptr_next   = ~ptr;
            end else if (vals[~ptr]) begin
                grant[~ptr] = 1'b1;
                ptr_next    = ptr;
            end
        end
    end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Shares one single-port synchronous SRAM between two val/rdy requesters,
// absorbing the 1-cycle read latency and buffering a stalled response.
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int p_data_nbits  = 32,
    parameter  int p_num_entries = 256,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic                     req0_type,
    input  logic [c_addr_nbits-1:0]  req0_addr,
    input  logic [c_data_nbytes-1:0] req0_byte_en,
    input  logic [p_data_nbits-1:0]  req0_data,

    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic                     req1_type,
    input  logic [c_addr_nbits-1:0]  req1_addr,
    input  logic [c_data_nbytes-1:0] req1_byte_en,
    input  logic [p_data_nbits-1:0]  req1_data,

    output logic                     resp0_val,
    input  logic                     resp0_rdy,
    output logic                     resp0_type,
    output logic [p_data_nbits-1:0]  resp0_data,

    output logic                     resp1_val,
    input  logic                     resp1_rdy,
    output logic                     resp1_type,
    output logic [p_data_nbits-1:0]  resp1_data,

    output logic                     sram_read_en,
    output logic [c_addr_nbits-1:0]  sram_read_addr,
    output logic                     sram_write_en,
    output logic [c_data_nbytes-1:0] sram_write_byte_en,
    output logic [c_addr_nbits-1:0]  sram_write_addr,
    output logic [p_data_nbits-1:0]  sram_write_data,
    input  logic [p_data_nbits-1:0]  sram_read_data
);

    pend_entry_t              pend;
    logic                     pend_val;
    logic                     hold_val;
    logic [p_data_nbits-1:0]  hold_data;
    logic                     rr_ptr;

    logic                     pend_rdy;
    logic                     can_issue;
    logic [1:0]               grant;
    logic                     ptr_next;
    logic                     gnt_any;
    logic                     gnt_port;
    logic                     g_type;
    logic [c_addr_nbits-1:0]  g_addr;
    logic [c_data_nbytes-1:0] g_byte_en;
    logic [p_data_nbits-1:0]  g_data;
    logic                     resp_active;
    logic [p_data_nbits-1:0]  resp_data;

    // The owner's resp_rdy feeds straight into the issue decision so a
    // consumed response frees the SRAM for a new access in the same cycle.
    assign pend_rdy  = pend.port ? resp1_rdy : resp0_rdy;
    assign can_issue = !hold_val && (!pend_val || pend_rdy);

    sram_arb_rr2 u_rr (
        .vals     ({req1_val, req0_val}),
        .ptr      (rr_ptr),
        .en       (can_issue && reset),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    assign gnt_any   = |grant;
    assign gnt_port  = grant[1];
    assign g_type    = gnt_port ? req1_type    : req0_type;
    assign g_addr    = gnt_port ? req1_addr    : req0_addr;
    assign g_byte_en = gnt_port ? req1_byte_en : req0_byte_en;
    assign g_data    = gnt_port ? req1_data    : req0_data;

    assign req0_rdy = grant[0];
    assign req1_rdy = grant[1];

    assign sram_read_en       = gnt_any && (g_type == TYPE_READ);
    assign sram_write_en      = gnt_any && (g_type == TYPE_WRITE);
    assign sram_read_addr     = sram_read_en  ? g_addr    : '0;
    assign sram_write_addr    = sram_write_en ? g_addr    : '0;
    assign sram_write_byte_en = sram_write_en ? g_byte_en : '0;
    assign sram_write_data    = sram_write_en ? g_data    : '0;

    assign resp_active = reset && (pend_val || hold_val);
    assign resp_data   = hold_val ? hold_data
                       : ((pend.req_type == TYPE_READ) ? sram_read_data : '0);

    assign resp0_val  = resp_active && !pend.port;
    assign resp1_val  = resp_active &&  pend.port;
    assign resp0_type = resp0_val && pend.req_type;
    assign resp1_type = resp1_val && pend.req_type;
    assign resp0_data = resp0_val ? resp_data : '0;
    assign resp1_data = resp1_val ? resp_data : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_val <= 1'b0;
            hold_val <= 1'b0;
            rr_ptr   <= 1'b0;
        end else begin
            rr_ptr   <= ptr_next;
            pend_val <= gnt_any;
            if (pend_val && !pend_rdy) begin
                hold_val <= 1'b1;
            end else if (hold_val && pend_rdy) begin
                hold_val <= 1'b0;
            end
        end
    end

    // Payload registers need no reset: they are only observed behind the valid flags.
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            pend <= '{port: gnt_port, req_type: g_type};
        end
        if (pend_val && !pend_rdy) begin
            hold_data <= resp_data;
        end
    end

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed bench for sram_1rw_arbiter with an SRAM model and a per-cycle reference model.
module tb_sram_1rw_arbiter;

  localparam int DW = 32;
  localparam int NE = 256;
  localparam int AW = 8;
  localparam int BW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req_val, req_rdy, req_type;
  logic [AW-1:0] req_addr [2];
  logic [BW-1:0] req_be   [2];
  logic [DW-1:0] req_data [2];
  logic [1:0]    resp_val, resp_rdy, resp_type;
  logic [DW-1:0] resp_data0, resp_data1;

  logic          sram_read_en, sram_write_en;
  logic [AW-1:0] sram_read_addr, sram_write_addr;
  logic [BW-1:0] sram_write_byte_en;
  logic [DW-1:0] sram_write_data;
  logic [DW-1:0] sram_rdata;

  sram_1rw_arbiter #(.p_data_nbits(DW), .p_num_entries(NE)) dut (
    .clk                (clk),
    .reset              (reset),
    .req0_val           (req_val[0]),
    .req0_rdy           (req_rdy[0]),
    .req0_type          (req_type[0]),
    .req0_addr          (req_addr[0]),
    .req0_byte_en       (req_be[0]),
    .req0_data          (req_data[0]),
    .req1_val           (req_val[1]),
    .req1_rdy           (req_rdy[1]),
    .req1_type          (req_type[1]),
    .req1_addr          (req_addr[1]),
    .req1_byte_en       (req_be[1]),
    .req1_data          (req_data[1]),
    .resp0_val          (resp_val[0]),
    .resp0_rdy          (resp_rdy[0]),
    .resp0_type         (resp_type[0]),
    .resp0_data         (resp_data0),
    .resp1_val          (resp_val[1]),
    .resp1_rdy          (resp_rdy[1]),
    .resp1_type         (resp_type[1]),
    .resp1_data         (resp_data1),
    .sram_read_en       (sram_read_en),
    .sram_read_addr     (sram_read_addr),
    .sram_write_en      (sram_write_en),
    .sram_write_byte_en (sram_write_byte_en),
    .sram_write_addr    (sram_write_addr),
    .sram_write_data    (sram_write_data),
    .sram_read_data     (sram_rdata)
  );

  // ---------------- SRAM model (1-cycle read latency) ----------------
  logic [DW-1:0] sram_mem [NE];
  always @(posedge clk) begin
    if (sram_read_en) sram_rdata <= sram_mem[sram_read_addr];
    if (sram_write_en)
      for (int b = 0; b < BW; b++)
        if (sram_write_byte_en[b]) sram_mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
  end

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int passed = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endfunction

  // ---------------- reference model ----------------
  // One outstanding response at most: presented first on the cycle after issue,
  // then held until its owner takes it. Priority flips to the other port on each grant.
  logic [DW-1:0] m_mem [NE];
  logic          m_busy = 1'b0;
  logic          m_first = 1'b0;
  logic          m_port = 1'b0;
  logic          m_type = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_prio = 1'b0;

  logic [1:0]    e_rdy, e_rval;
  logic          e_ren, e_wen, can;
  logic [AW-1:0] e_raddr, e_waddr;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_wdata, e_rd0, e_rd1;
  int            g;

  always @(negedge clk) begin
    e_rdy = '0; e_rval = '0; e_ren = 0; e_wen = 0;
    e_raddr = '0; e_waddr = '0; e_be = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    g = -1;
    if (reset) begin
      can = !m_busy || (m_first && resp_rdy[m_port]);
      if (can) begin
        if (req_val[m_prio]) g = int'(m_prio);
        else if (req_val[!m_prio]) g = int'(!m_prio);
      end
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        if (req_type[g] == 1'b0) begin
          e_ren = 1'b1; e_raddr = req_addr[g];
        end else begin
          e_wen = 1'b1; e_waddr = req_addr[g]; e_be = req_be[g]; e_wdata = req_data[g];
        end
      end
      if (m_busy) begin
        e_rval[m_port] = 1'b1;
        if (m_port) e_rd1 = m_data; else e_rd0 = m_data;
      end
    end
    check("req_rdy", req_rdy, e_rdy);
    check("read_en", sram_read_en, e_ren);
    check("write_en", sram_write_en, e_wen);
    check("en_exclusive", sram_read_en & sram_write_en, 0);
    check("read_addr", sram_read_addr, e_raddr);
    check("write_addr", sram_write_addr, e_waddr);
    check("write_be", sram_write_byte_en, e_be);
    check("write_data", sram_write_data, e_wdata);
    check("resp_val", resp_val, e_rval);
    check("resp0_data", resp_data0, e_rd0);
    check("resp1_data", resp_data1, e_rd1);
    if (m_busy && reset) check("resp_type", resp_type[m_port], m_type);

    if (!reset) begin
      m_busy = 1'b0;
      m_prio = 1'b0;
    end else if (g >= 0) begin
      m_busy  = 1'b1;
      m_first = 1'b1;
      m_port  = g[0];
      m_type  = req_type[g];
      m_prio  = (g == 0);
      if (req_type[g] == 1'b0) begin
        m_data = m_mem[req_addr[g]];
      end else begin
        m_data = '0;
        for (int b = 0; b < BW; b++)
          if (req_be[g][b]) m_mem[req_addr[g]][8*b +: 8] = req_data[g][8*b +: 8];
      end
    end else if (m_busy) begin
      if (resp_rdy[m_port]) m_busy = 1'b0;
      else m_first = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_val = '0; req_type = '0; resp_rdy = 2'b11;
    for (int p = 0; p < 2; p++) begin
      req_addr[p] = '0; req_be[p] = '0; req_data[p] = '0;
    end
  endtask

  task automatic drv(input int p, input logic t, input logic [AW-1:0] a,
                     input logic [BW-1:0] be, input logic [DW-1:0] d);
    req_val[p] = 1'b1; req_type[p] = t; req_addr[p] = a; req_be[p] = be; req_data[p] = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < NE; i++) begin
      sram_mem[i] = '0;
      m_mem[i] = '0;
    end
    sram_rdata = '0;
    idle();
    reset = 1'b0;
    drv(0, 1'b0, 8'd0, 4'h0, 32'h0);

    // Reset held with a pending request: nothing may move.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req0_rdy", req_rdy[0], 0);
      check("rst_sram_en", {sram_read_en, sram_write_en}, 0);
      check("rst_resp_val", resp_val, 0);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_grant0", req_rdy, 2'b01);
    tick();
    idle();
    @(negedge clk);
    tick();

    // Single write then read on port 0.
    drv(0, 1'b1, 8'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    tick();
    idle();
    drv(0, 1'b0, 8'd5, 4'h0, 32'h0);
    @(negedge clk);
    check("wr_resp_val", resp_val, 2'b01);
    check("wr_resp_type", resp_type[0], 1);
    check("wr_resp_data", resp_data0, 0);
    tick();
    idle();
    @(negedge clk);
    check("rd_resp_type", resp_type[0], 0);
    check("rd_resp_data", resp_data0, 32'hDEADBEEF);
    tick();

    // Contention: both ports read continuously; port 1 holds priority now.
    for (int i = 0; i < 8; i++) begin
      drv(0, 1'b0, 8'd5, 4'h0, 32'h0);
      drv(1, 1'b0, 8'd5, 4'h0, 32'h0);
      @(negedge clk);
      check("alt_grant1", req_rdy[1], (i % 2 == 0));
      check("alt_one_access", 32'(sram_read_en) + 32'(sram_write_en), 1);
      tick();
    end
    idle();
    @(negedge clk);
    tick();

    // Back-pressure on port 1.
    drv(0, 1'b1, 8'd7, 4'hF, 32'h12345678);
    @(negedge clk);
    tick();
    idle();
    @(negedge clk);
    tick();
    drv(1, 1'b0, 8'd7, 4'h0, 32'h0);
    resp_rdy[1] = 1'b0;
    @(negedge clk);
    check("bp_grant1", req_rdy, 2'b10);
    tick();
    drv(0, 1'b0, 8'd0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_no_grant", req_rdy, 0);
      check("bp_resp_val", resp_val, 2'b10);
      check("bp_resp_data", resp_data1, 32'h12345678);
      tick();
    end
    resp_rdy[1] = 1'b1;
    @(negedge clk);
    check("bp_consume_val", resp_data1, 32'h12345678);
    check("bp_consume_nogrant", req_rdy, 0);
    tick();
    @(negedge clk);
    check("bp_next_grant", req_rdy, 2'b01);
    check("bp_resp_gone", resp_val[1], 0);
    tick();
    idle();
    @(negedge clk);
    tick();

    // Byte enables over a cleared word.
    drv(0, 1'b1, 8'd9, 4'hF, 32'h0);
    @(negedge clk);
    tick();
    drv(0, 1'b1, 8'd9, 4'h5, 32'hAABBCCDD);
    @(negedge clk);
    tick();
    drv(0, 1'b0, 8'd9, 4'h0, 32'h0);
    @(negedge clk);
    tick();
    idle();
    @(negedge clk);
    check("be_read_data", resp_data0, 32'h00BB00DD);
    tick();

    // Reset right after a read grant drops the response.
    drv(1, 1'b0, 8'd5, 4'h0, 32'h0);
    @(negedge clk);
    check("mid_grant1", req_rdy[1], 1);
    tick();
    idle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_no_resp", resp_val, 0);
    tick();
    @(negedge clk);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_after_rst_no_resp", resp_val, 0);
    tick();
    drv(1, 1'b0, 8'd5, 4'h0, 32'h0);
    drv(0, 1'b0, 8'd9, 4'h0, 32'h0);
    @(negedge clk);
    check("mid_after_rst_prio0", req_rdy, 2'b01);
    tick();
    idle();
    repeat (3) begin
      @(negedge clk);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
